// File: rtl/spi_pkg.sv
// Shared definitions for the SPI chip-select / serial-clock generator.
package spi_pkg;

    localparam logic [1:0] MODE_RD     = 2'b00;
    localparam logic [1:0] MODE_WR     = 2'b01;
    localparam logic [1:0] MODE_CMD_RD = 2'b10;

    localparam int MAX_BITS = 64;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    // Bits clocked in one frame for a given mode and widths.
    function automatic logic [6:0] calc_tot(input logic [1:0] mode,
                                            input logic [5:0] wr,
                                            input logic [5:0] rd);
        logic [6:0] t;
        case (mode)
            MODE_RD:            t = {1'b0, rd};
            MODE_WR:            t = {1'b0, wr};
            MODE_CMD_RD, 2'b11: t = {1'b0, wr} + {1'b0, rd};
            default:            t = '0;
        endcase
        if (t > 7'(MAX_BITS)) t = 7'(MAX_BITS);
        return t;
    endfunction

endpackage

// File: rtl/spi_sck_gen_if.sv
// Request/config inputs and cs/sck outputs of spi_sck_gen.
interface spi_sck_gen_if;
    logic       cs_sck_en;
    logic       cpol;
    logic       cpha;
    logic [1:0] w_r_mode;
    logic [5:0] wr_width;
    logic [5:0] rd_width;
    logic       cs;
    logic       sck;
    logic       busy;
    logic       frame_done;

    modport master (
        input  cs_sck_en, cpol, cpha, w_r_mode, wr_width, rd_width,
        output cs, sck, busy, frame_done
    );

    modport slave (
        output cs_sck_en, cpol, cpha, w_r_mode, wr_width, rd_width,
        input  cs, sck, busy, frame_done
    );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick on every CLK_DIV-th enabled cycle.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] cnt;

    assign tick = en && (cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/spi_sck_gen.sv
// SPI master cs/sck framing: setup, 2*tot sck half-periods, hold, then idle gap.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_sck_gen_if.master  bus
);
    localparam int GW = $clog2(CS_IDLE + 1);

    state_t        state;
    logic          cs_q, sck_q, busy_q, done_q;
    logic          cpol_q;
    logic [6:0]    tot_q;
    logic [7:0]    edge_cnt;
    logic [15:0]   cnt;
    logic [GW-1:0] gap, gap_inc;
    logic [6:0]    tot_in;
    logic          tick;

    assign bus.cs         = cs_q;
    assign bus.sck        = sck_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

    assign tot_in = calc_tot(bus.w_r_mode, bus.wr_width, bus.rd_width);

    // Start compares the incremented count so the cs-high gap is exactly CS_IDLE cycles.
    assign gap_inc = (gap == GW'(CS_IDLE)) ? gap : gap + 1'b1;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != SHIFT),
        .en    (state == SHIFT),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cs_q     <= 1'b1;
            sck_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            gap      <= GW'(CS_IDLE);
            cpol_q   <= 1'b0;
            tot_q    <= '0;
            edge_cnt <= '0;
            cnt      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    sck_q    <= bus.cpol;
                    cs_q     <= 1'b1;
                    busy_q   <= 1'b0;
                    gap      <= gap_inc;
                    cnt      <= '0;
                    edge_cnt <= '0;
                    if (bus.cs_sck_en && gap_inc == GW'(CS_IDLE)) begin
                        cpol_q <= bus.cpol;
                        tot_q  <= tot_in;
                        busy_q <= 1'b1;
                        if (tot_in == '0) begin
                            done_q <= 1'b1;
                            gap    <= '0;
                        end else begin
                            state <= SETUP;
                            cs_q  <= 1'b0;
                        end
                    end
                end
                SETUP: begin
                    sck_q <= cpol_q;
                    cnt   <= cnt + 16'd1;
                    if (cnt == 16'(CS_SETUP - 1)) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sck_q    <= ~sck_q;
                        edge_cnt <= edge_cnt + 8'd1;
                        if (edge_cnt == {tot_q, 1'b0} - 8'd1) state <= HOLD;
                    end
                end
                HOLD: begin
                    cnt <= cnt + 16'd1;
                    if (cnt == 16'(CS_HOLD - 1)) begin
                        cs_q   <= 1'b1;
                        done_q <= 1'b1;
                        state  <= IDLE;
                        gap    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_sck_gen.sv
// Directed checks of spi_sck_gen framing with CLK_DIV=2 and 2-cycle setup/hold/idle.
module tb_spi_sck_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    spi_sck_gen_if bus();

    spi_sck_gen #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cpol;
        logic       cpha;
        logic [1:0] mode;
        logic [5:0] wr;
        logic [5:0] rd;
        int         low;
        int         edges;
        int         off;
        int         done_idx;
        int         sck_end;
    } vec_t;

    typedef struct {
        int low, rises, falls, off, rise_idx, done_cnt, done_idx, busy_cnt, sck_at_rise, simul;
    } meas_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Configure, pulse cs_sck_en for one cycle, then observe the frame sample by sample.
    task automatic measure(input vec_t v, output meas_t m);
        int first_low, first_edge, pcs, psck;
        m = '{default: 0};
        first_low = 0;
        first_edge = 0;
        bus.cpol = v.cpol; bus.cpha = v.cpha; bus.w_r_mode = v.mode;
        bus.wr_width = v.wr; bus.rd_width = v.rd; bus.cs_sck_en = 1'b0;
        @(negedge clk);
        bus.cs_sck_en = 1'b1;
        pcs = int'(bus.cs);
        psck = int'(bus.sck);
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (i == 1) bus.cs_sck_en = 1'b0;
            if (i == 3) begin
                bus.cpol = ~v.cpol; bus.w_r_mode = ~v.mode;
                bus.wr_width = 6'd31; bus.rd_width = 6'd31;
            end
            if (!bus.cs) begin
                m.low++;
                if (first_low == 0) first_low = i;
            end
            if (int'(bus.sck) != psck && int'(bus.cs) != pcs) m.simul++;
            if (!bus.cs && bus.sck && psck == 0) begin
                m.rises++;
                if (first_edge == 0) first_edge = i;
            end
            if (!bus.cs && !bus.sck && psck == 1) begin
                m.falls++;
                if (first_edge == 0) first_edge = i;
            end
            if (bus.cs && pcs == 0) begin
                m.rise_idx = i;
                m.sck_at_rise = int'(bus.sck);
            end
            if (bus.frame_done) begin
                m.done_cnt++;
                if (m.done_idx == 0) m.done_idx = i;
            end
            if (bus.busy) m.busy_cnt++;
            pcs = int'(bus.cs);
            psck = int'(bus.sck);
            if (m.done_idx != 0 && i >= m.done_idx + 4) break;
        end
        m.off = (first_edge != 0) ? first_edge - first_low : 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        meas_t m;
        int nf, nd, gap_run, ngaps, was_high;
        int gaps[2];
        string p;

        // cpol cpha mode wr rd | low edges off done_idx sck_end
        vecs[0] = '{1'b0, 1'b0, 2'b00, 6'd0,  6'd8,  36,  8, 4,  37, 0};
        vecs[1] = '{1'b1, 1'b1, 2'b00, 6'd0,  6'd8,  36,  8, 4,  37, 1};
        vecs[2] = '{1'b0, 1'b0, 2'b10, 6'd8,  6'd16, 100, 24, 4, 101, 0};
        vecs[3] = '{1'b0, 1'b0, 2'b00, 6'd9,  6'd0,  0,   0, 0,   1, 0};
        vecs[4] = '{1'b0, 1'b0, 2'b01, 6'd5,  6'd20, 24,  5, 4,  25, 0};
        vecs[5] = '{1'b1, 1'b0, 2'b11, 6'd1,  6'd1,  12,  2, 4,  13, 1};

        bus.cs_sck_en = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.w_r_mode = 2'b00; bus.wr_width = '0; bus.rd_width = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset cs", int'(bus.cs), 1);
        check("reset sck", int'(bus.sck), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.frame_done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            measure(vecs[k], m);
            p = $sformatf("v%0d", k);
            check({p, " cs_low"}, m.low, vecs[k].low);
            check({p, " rises"}, m.rises, vecs[k].edges);
            check({p, " falls"}, m.falls, vecs[k].edges);
            check({p, " first_edge_off"}, m.off, vecs[k].off);
            check({p, " done_cnt"}, m.done_cnt, 1);
            check({p, " done_idx"}, m.done_idx, vecs[k].done_idx);
            check({p, " cs_rise_idx"}, m.rise_idx, (vecs[k].low == 0) ? 0 : vecs[k].done_idx);
            check({p, " busy_cycles"}, m.busy_cnt, vecs[k].done_idx);
            check({p, " cs_sck_same_cycle"}, m.simul, 0);
            if (vecs[k].low != 0) check({p, " sck_at_cs_rise"}, m.sck_at_rise, vecs[k].sck_end);
            repeat (4) @(negedge clk);
        end

        // Back-to-back frames with cs_sck_en held; drop it once the third frame starts.
        bus.cpol = 1'b0; bus.w_r_mode = 2'b00; bus.rd_width = 6'd8; bus.wr_width = 6'd0;
        @(negedge clk);
        bus.cs_sck_en = 1'b1;
        nf = 0; nd = 0; ngaps = 0; gap_run = 0; was_high = 1;
        gaps[0] = 0; gaps[1] = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.cs && was_high == 1) begin
                nf++;
                if (nf > 1 && ngaps < 2) begin
                    gaps[ngaps] = gap_run;
                    ngaps++;
                end
                if (nf == 3) bus.cs_sck_en = 1'b0;
            end
            gap_run = bus.cs ? gap_run + 1 : 0;
            was_high = int'(bus.cs);
            if (bus.frame_done) nd++;
        end
        check("b2b frames", nf, 3);
        check("b2b done pulses", nd, 3);
        check("b2b gap0", gaps[0], 2);
        check("b2b gap1", gaps[1], 2);

        // cs_sck_en held into SHIFT then dropped: one complete frame only.
        @(negedge clk);
        bus.cs_sck_en = 1'b1;
        nf = 0; nd = 0; was_high = 1; gap_run = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 5) bus.cs_sck_en = 1'b0;
            if (!bus.cs && was_high == 1) nf++;
            if (!bus.cs) gap_run++;
            was_high = int'(bus.cs);
            if (bus.frame_done) nd++;
        end
        check("drop frames", nf, 1);
        check("drop cs_low", gap_run, 36);
        check("drop done pulses", nd, 1);

        // Reset in the middle of SHIFT while sck is high.
        repeat (2) @(negedge clk);
        bus.cs_sck_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) bus.cs_sck_en = 1'b0;
        end
        check("pre-reset sck high", int'(bus.sck), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset cs", int'(bus.cs), 1);
        check("async reset sck", int'(bus.sck), 0);
        check("async reset busy", int'(bus.busy), 0);
        nd = 0;
        @(negedge clk);
        if (bus.frame_done) nd++;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.frame_done) nd++;
        end
        check("reset no done", nd, 0);
        measure(vecs[0], m);
        check("post-reset cs_low", m.low, 36);
        check("post-reset rises", m.rises, 8);
        check("post-reset done_idx", m.done_idx, 37);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
